viterbi_dec_param: RTL and testbench
====================================

// Module: viterbi_dec_param
// PURPOSE
// Parametrised hard-decision Viterbi decoder, rate 1/2, constraint length K.
// Successor to the fixed K=3 decoder: runs on a single clock with a per-symbol valid strobe instead of a divided clock.
// Adds configurable generators, traceback depth and metric width, frame restart, and a path-metric output.
// Sits after the channel slicer; feeds the descrambler/sink.
// PARAMETERS
// K          3       constraint length, 3..7; NS = 2^(K-1) states
// G0         3'b111  generator for code bit c0, K bits; bit K-1 taps the newest input bit
// G1         3'b101  generator for code bit c1, K bits
// TB_DEPTH   15      survivor length in bits, >= 2
// METRIC_W   6       path-metric width; must satisfy 2^(METRIC_W-1) > 8*(K-1)
// PORTS
// clk          in   1         system clock, rising edge
// reset        in   1         synchronous, active-high
// frame_start  in   1         restart trellis at state 0; may coincide with in_valid
// in_valid     in   1         in_sym accepted on this edge
// in_sym       in   2         {c0,c1} hard code bits
// out_valid    out  1         one-cycle pulse, out_bit valid
// out_bit      out  1         decoded information bit
// best_metric  out  METRIC_W  smallest path metric after last accepted symbol
// BEHAVIOUR
// - State s is the last K-1 inputs, newest bit in the MSB. Successor of s on input u is {u, s[K-2:1]}.
// - Code bits for that branch: r = {u, s}; c0 = ^(r & G0); c1 = ^(r & G1).
// - Branch metric = Hamming distance(in_sym, {c0,c1}), range 0..2.
// - ACS runs on each accepted symbol: new[s] = min over b of old[{s[K-3:0],b}] + bm.
//   - Tie: predecessor with b=0 wins.
//   - K=3 edge case: the predecessor of s is {s[0],b}.
// - Register-exchange survivors: surv[s] <= {surv[pred][TB_DEPTH-2:0], s[K-2]}. Oldest bit is the MSB.
// - Normalisation: if every new metric has its MSB set, clear the MSB in all of them, in the same cycle.
//   - Metrics never wrap.
//   - best_metric reports the normalised value.
// - Best state = lowest metric among the registered metrics. Tie: lowest state index.
// - Output, for an accepted symbol with index n counted from 0 since reset/frame_start:
//   - When n >= TB_DEPTH-1, out_valid=1 on the next edge, with out_bit = MSB of surv[best].
//   - That bit is the decision for symbol n-TB_DEPTH+1.
//   - Otherwise out_valid=0.
// - Latency: exactly 1 cycle from the accept edge to out_valid, plus TB_DEPTH-1 symbols of fill.
// - in_valid=0: no state change; out_valid=0 on the next edge. Gaps of any length are allowed.
// - Reset and frame_start initial values:
//   - metric[0]=0, other metrics = 4*(K-1).
//   - Survivors 0, symbol counter 0.
//   - out_valid=0, out_bit=0, best_metric=0.
// - frame_start together with in_valid: the symbol is index 0 of the new frame and is applied to the initial metrics.
// - frame_start alone: initialise only. Undelivered bits of the old frame are discarded.
// - Reset mid-frame: identical to frame_start; reset has priority over everything.
// - Symbol counter saturates at TB_DEPTH-1.
// STRUCTURE
// - Package viterbi_pkg holds:
//   - NS = 2^(K-1) and bm_f(sym, state, u), the branch-metric function.
//   - enc_bits_f(state, u, G0, G1).
//   - INIT_METRIC(K) = 4*(K-1), and the default generators for K=3,5,7 (7/5, 23/35, 171/133 octal).
// - One sub-module, viterbi_acs: two adds, compare, select; outputs the new metric and the decision bit.
//   - Instantiated NS times by generate.
// - Top level holds:
//   - Metric and survivor arrays, normaliser.
//   - Best-state min tree: combinational on registered metrics.
//   - Symbol counter and output register.
// TESTING
// - Reset: hold reset 3 cycles with in_valid=1 -> out_valid=0, out_bit=0, best_metric=0 throughout.
// - Clean stream, K=3, 7/5, TB_DEPTH=8:
//   - Stimulus: encode 1,0,0,1,0,1,0,0,1,0,1,1,0,0 then 8 zero-bits.
//   - Required: first out_valid 1 cycle after the 8th symbol; out_bits equal the 14 info bits in order; best_metric stays 0.
// - Errors: same stream with 1 bit flipped in symbols 2, 9, 16 -> decoded bits unchanged; best_metric ends at 3.
// - Valid gaps: insert 0-5 idle cycles randomly between symbols -> identical out_bit sequence; each out_valid exactly 1 cycle after its accept edge.
// - frame_start:
//   - Assert after symbol 10 (alone) -> no out_valid for the next 7 accepted symbols; the new frame decodes correctly.
//   - Repeat with frame_start coincident with in_valid.
// - Long run / normalisation: 5000 all-zero symbols with a 2% bit-error rate, K=7 (171/133), TB_DEPTH=35, METRIC_W=8 -> all decoded 0; best_metric < 128 at all times, never wraps.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the parametrised Viterbi decoder.
// State s holds the last K-1 inputs, newest bit in the MSB.
package viterbi_pkg;

  localparam int unsigned G0_K3 = 'o7;
  localparam int unsigned G1_K3 = 'o5;
  localparam int unsigned G0_K5 = 'o23;
  localparam int unsigned G1_K5 = 'o35;
  localparam int unsigned G0_K7 = 'o171;
  localparam int unsigned G1_K7 = 'o133;

  function automatic int unsigned ns_f(input int unsigned k);
    return 32'd1 << (k - 1);
  endfunction

  function automatic int unsigned init_metric_f(input int unsigned k);
    return 4 * (k - 1);
  endfunction

  // Code bits {c0,c1} for the branch leaving `state` on input u.
  function automatic logic [1:0] enc_bits_f(input logic [31:0] state, input logic u,
                                            input logic [31:0] g0, input logic [31:0] g1,
                                            input int unsigned k);
    logic [31:0] r;
    r = state | (32'(u) << (k - 1));
    return {^(r & g0), ^(r & g1)};
  endfunction

  function automatic logic [1:0] bm_f(input logic [1:0] sym, input logic [31:0] state,
                                      input logic u, input logic [31:0] g0,
                                      input logic [31:0] g1, input int unsigned k);
    logic [1:0] d;
    d = sym ^ enc_bits_f(state, u, g0, g1, k);
    return {d[1] & d[0], d[1] ^ d[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: two candidate paths, lower sum wins.
// On equal sums the b=0 predecessor is kept, so dec_o is 1 only for a strict win.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int METRIC_W = 6
) (
  input  logic [METRIC_W-1:0] metric0_i,
  input  logic [METRIC_W-1:0] metric1_i,
  input  logic [1:0]          bm0_i,
  input  logic [1:0]          bm1_i,
  output logic [METRIC_W-1:0] metric_o,
  output logic                dec_o
);

  logic [METRIC_W-1:0] sum0;
  logic [METRIC_W-1:0] sum1;

  assign sum0     = metric0_i + METRIC_W'(bm0_i);
  assign sum1     = metric1_i + METRIC_W'(bm1_i);
  assign dec_o    = (sum1 < sum0);
  assign metric_o = dec_o ? sum1 : sum0;

endmodule

// File: rtl/viterbi_dec_param.sv
// Rate-1/2 hard-decision Viterbi decoder, constraint length K, register-exchange survivors.
// One symbol per in_valid strobe; each decision appears TB_DEPTH-1 symbols after its own symbol.
module viterbi_dec_param
  import viterbi_pkg::*;
#(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = 3'b111,
  parameter logic [K-1:0]   G1       = 3'b101,
  parameter int             TB_DEPTH = 15,
  parameter int             METRIC_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                in_valid,
  input  logic [1:0]          in_sym,
  output logic                out_valid,
  output logic                out_bit,
  output logic [METRIC_W-1:0] best_metric
);

  localparam int NS    = int'(ns_f(K));
  localparam int S_W   = K - 1;
  localparam int CNT_W = $clog2(TB_DEPTH);
  localparam logic [METRIC_W-1:0] INIT_M  = METRIC_W'(init_metric_f(K));
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TB_DEPTH - 1);

  logic [METRIC_W-1:0] metric_q   [NS];
  logic [METRIC_W-1:0] metric_src [NS];
  logic [METRIC_W-1:0] acs_metric [NS];
  logic [METRIC_W-1:0] metric_d   [NS];
  logic [TB_DEPTH-1:0] surv_q     [NS];
  logic [TB_DEPTH-1:0] surv_src   [NS];
  logic [TB_DEPTH-1:0] surv_d     [NS];
  logic [NS-1:0]       dec;
  logic                all_msb;
  logic [METRIC_W-1:0] best_m;
  logic [S_W-1:0]      best_s;
  logic [CNT_W-1:0]    cnt_q;
  logic                acc_q;
  logic                emit_q;
  logic                out_valid_q;
  logic                out_bit_q;
  logic [METRIC_W-1:0] best_metric_q;

  // A symbol that arrives with frame_start is applied to the initial trellis.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      if (frame_start) begin
        metric_src[s] = (s == 0) ? '0 : INIT_M;
        surv_src[s]   = '0;
      end else begin
        metric_src[s] = metric_q[s];
        surv_src[s]   = surv_q[s];
      end
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_acs
    localparam int   P0 = (2 * s) % NS;
    localparam logic U  = 1'((s >> (K - 2)) & 1);
    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = bm_f(in_sym, 32'(P0), U, 32'(G0), 32'(G1), K);
    assign bm1 = bm_f(in_sym, 32'(P0 + 1), U, 32'(G0), 32'(G1), K);

    viterbi_acs #(.METRIC_W(METRIC_W)) u_acs (
      .metric0_i (metric_src[P0]),
      .metric1_i (metric_src[P0 + 1]),
      .bm0_i     (bm0),
      .bm1_i     (bm1),
      .metric_o  (acs_metric[s]),
      .dec_o     (dec[s])
    );
  end

  always_comb begin
    int p;
    p = 0;
    for (int s = 0; s < NS; s++) begin
      p         = (2 * s) % NS + int'(dec[s]);
      surv_d[s] = {surv_src[p][TB_DEPTH-2:0], 1'((s >> (K - 2)) & 1)};
    end
  end

  // Metric spread is bounded, so once every metric has its MSB set it can be dropped from all.
  always_comb begin
    all_msb = 1'b1;
    for (int s = 0; s < NS; s++) all_msb = all_msb & acs_metric[s][METRIC_W-1];
    for (int s = 0; s < NS; s++) begin
      metric_d[s] = acs_metric[s];
      if (all_msb) metric_d[s][METRIC_W-1] = 1'b0;
    end
  end

  always_comb begin
    best_m = metric_q[0];
    best_s = '0;
    for (int s = 1; s < NS; s++) begin
      if (metric_q[s] < best_m) begin
        best_m = metric_q[s];
        best_s = S_W'(s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        metric_q[s] <= (s == 0) ? '0 : INIT_M;
        surv_q[s]   <= '0;
      end
      cnt_q         <= '0;
      acc_q         <= 1'b0;
      emit_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      best_metric_q <= '0;
    end else begin
      acc_q       <= in_valid;
      emit_q      <= in_valid && !frame_start && (cnt_q == CNT_MAX);
      out_valid_q <= emit_q && !frame_start;
      if (frame_start) begin
        out_bit_q     <= 1'b0;
        best_metric_q <= '0;
      end else begin
        if (emit_q) out_bit_q <= surv_q[best_s][TB_DEPTH-1];
        if (acc_q) best_metric_q <= best_m;
      end
      if (in_valid) begin
        for (int s = 0; s < NS; s++) begin
          metric_q[s] <= metric_d[s];
          surv_q[s]   <= surv_d[s];
        end
        if (frame_start) cnt_q <= CNT_W'(1);
        else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end else if (frame_start) begin
        for (int s = 0; s < NS; s++) begin
          metric_q[s] <= metric_src[s];
          surv_q[s]   <= '0;
        end
        cnt_q <= '0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign best_metric = best_metric_q;

endmodule

// File: tb/tb_viterbi_dec_param.sv
// Bench for viterbi_dec_param: K=3 short-traceback instance for framing/latency cases,
// K=7 instance for a long noisy all-zero run that exercises metric normalisation.
module tb_viterbi_dec_param;
  import viterbi_pkg::*;

  localparam int A_TB = 8;
  localparam int B_TB = 35;
  localparam int B_N  = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_fs, a_iv, a_ov, a_ob;
  logic [1:0] a_sym;
  logic [5:0] a_bm;
  logic       b_reset, b_fs, b_iv, b_ov, b_ob;
  logic [1:0] b_sym;
  logic [7:0] b_bm;

  viterbi_dec_param #(.K(3), .G0(3'b111), .G1(3'b101), .TB_DEPTH(A_TB), .METRIC_W(6)) u_a (
    .clk(clk), .reset(a_reset), .frame_start(a_fs), .in_valid(a_iv), .in_sym(a_sym),
    .out_valid(a_ov), .out_bit(a_ob), .best_metric(a_bm));

  viterbi_dec_param #(.K(7), .G0(7'(G0_K7)), .G1(7'(G1_K7)), .TB_DEPTH(B_TB), .METRIC_W(8)) u_b (
    .clk(clk), .reset(b_reset), .frame_start(b_fs), .in_valid(b_iv), .in_sym(b_sym),
    .out_valid(b_ov), .out_bit(b_ob), .best_metric(b_bm));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference encoder and expected-output bookkeeping
  bit         info_q[$];
  logic [1:0] sym_q[$];
  bit         a_exp_bit[$];
  int         a_exp_n[$];
  bit         a_got_bit[$];
  int         a_got_n[$];
  int         a_got_bm[$];

  function automatic void encode(input int k, input int g0, input int g1);
    int st;
    int r;
    st = 0;
    sym_q.delete();
    foreach (info_q[i]) begin
      r  = (int'(info_q[i]) << (k - 1)) | st;
      sym_q.push_back({^(r & g0), ^(r & g1)});
      st = (int'(info_q[i]) << (k - 2)) | (st >> 1);
    end
  endfunction

  function automatic void set_info_fixed();
    bit base [14] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0};
    info_q.delete();
    foreach (base[i]) info_q.push_back(base[i]);
    repeat (8) info_q.push_back(1'b0);
  endfunction

  function automatic void set_info_random(input int n_rand, input int n_tail);
    info_q.delete();
    repeat (n_rand) info_q.push_back(1'($urandom_range(0, 1)));
    repeat (n_tail) info_q.push_back(1'b0);
  endfunction

  // Decision for symbol i is delivered with the accept of symbol i+TB-1.
  function automatic void a_expect();
    for (int i = 0; i + A_TB - 1 < sym_q.size(); i++) begin
      a_exp_bit.push_back(info_q[i]);
      a_exp_n.push_back(i + A_TB - 1);
    end
  endfunction

  task automatic a_send(input logic [1:0] s, input bit fs, input int gap);
    a_iv  = 1'b1;
    a_sym = s;
    a_fs  = fs;
    @(negedge clk);
    a_iv = 1'b0;
    a_fs = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic a_play(input int max_gap, input bit fs_first);
    foreach (sym_q[i]) a_send(sym_q[i], fs_first && (i == 0), $urandom_range(0, max_gap));
  endtask

  task automatic a_frame_start_alone();
    a_fs = 1'b1;
    @(negedge clk);
    a_fs = 1'b0;
    @(negedge clk);
  endtask

  task automatic a_compare(input string tag, input bit zero_best);
    chk({tag, "_count"}, a_got_bit.size(), a_exp_bit.size());
    for (int i = 0; i < a_exp_bit.size() && i < a_got_bit.size(); i++) begin
      chk({tag, "_bit"}, a_got_bit[i], a_exp_bit[i]);
      chk({tag, "_lat"}, a_got_n[i], a_exp_n[i]);
      if (zero_best) chk({tag, "_best"}, a_got_bm[i], 0);
    end
    a_exp_bit.delete(); a_exp_n.delete();
    a_got_bit.delete(); a_got_n.delete(); a_got_bm.delete();
  endtask

  // Monitor A: tag each output with the frame index of the symbol accepted one edge earlier.
  int a_cnt = 0;
  int a_prev_n = -1;
  always @(posedge clk) begin
    int cur_n;
    cur_n = -1;
    if (a_reset || a_fs) a_cnt = 0;
    if (a_iv && !a_reset) begin
      cur_n = a_cnt;
      a_cnt++;
    end
    #1;
    if (a_ov) begin
      a_got_bit.push_back(a_ob);
      a_got_n.push_back(a_prev_n);
      a_got_bm.push_back(int'(a_bm));
    end
    a_prev_n = cur_n;
  end

  // Monitor B: all-zero source, so the true path metric equals the injected bit errors.
  int b_errs = 0;
  int b_e_prev = 0;
  int b_norm = 0;
  int b_prev_bm = -1;
  int b_nout = 0;
  always @(posedge clk) begin
    int e_now;
    int d;
    e_now = (b_iv && !b_reset) ? $countones(b_sym) : 0;
    #1;
    b_errs += b_e_prev;
    b_e_prev = e_now;
    if (b_ov) begin
      b_nout++;
      chk("long_bit", b_ob, 0);
      chk("long_best_lt128", int'(b_bm) < 128, 1);
      if (b_prev_bm >= 0) begin
        d = int'(b_bm) - b_prev_bm;
        chk("long_best_step", (d >= 0 && d <= 2) || (d >= -128 && d <= -126), 1);
        if (d < 0) b_norm++;
      end
      chk("long_best_bound", int'(b_bm) + 128 * b_norm <= b_errs, 1);
      b_prev_bm = int'(b_bm);
    end
  end

  initial begin
    int pos;
    logic [1:0] s;
    pos = 0;
    a_reset = 1'b1; b_reset = 1'b1;
    a_fs = 1'b0; b_fs = 1'b0;
    a_iv = 1'b1; b_iv = 1'b1;
    a_sym = 2'b11; b_sym = 2'b10;
    repeat (3) begin
      @(negedge clk);
      a_sym = 2'($urandom_range(0, 3));
      chk("rst_out_valid", a_ov, 0);
      chk("rst_out_bit", a_ob, 0);
      chk("rst_best", a_bm, 0);
      chk("rst_b_out_valid", b_ov, 0);
    end
    a_reset = 1'b0; b_reset = 1'b0;
    a_iv = 1'b0; b_iv = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", a_ov, 0);

    // Clean stream
    set_info_fixed();
    encode(3, 'o7, 'o5);
    a_expect();
    a_play(0, 1'b0);
    repeat (3) @(negedge clk);
    a_compare("clean", 1'b1);
    chk("clean_best_end", a_bm, 0);

    // Single-bit errors in symbols 2, 9, 16
    a_frame_start_alone();
    set_info_fixed();
    encode(3, 'o7, 'o5);
    sym_q[2]  = sym_q[2]  ^ (2'b01 << $urandom_range(0, 1));
    sym_q[9]  = sym_q[9]  ^ (2'b01 << $urandom_range(0, 1));
    sym_q[16] = sym_q[16] ^ (2'b01 << $urandom_range(0, 1));
    a_expect();
    a_play(0, 1'b0);
    repeat (3) @(negedge clk);
    a_compare("errors", 1'b0);
    chk("errors_best_end", a_bm, 3);

    // Random idle gaps between symbols
    a_frame_start_alone();
    set_info_fixed();
    encode(3, 'o7, 'o5);
    a_expect();
    a_play(5, 1'b0);
    repeat (3) @(negedge clk);
    a_compare("gaps", 1'b1);

    // frame_start alone after symbol 10, then a fresh frame
    a_frame_start_alone();
    set_info_random(11, 0);
    encode(3, 'o7, 'o5);
    a_expect();
    a_play(2, 1'b0);
    @(negedge clk);
    a_frame_start_alone();
    set_info_random(14, 8);
    encode(3, 'o7, 'o5);
    a_expect();
    a_play(2, 1'b0);
    repeat (3) @(negedge clk);
    a_compare("fs_alone", 1'b1);

    // frame_start coincident with the first symbol of the new frame
    a_frame_start_alone();
    set_info_random(11, 0);
    encode(3, 'o7, 'o5);
    a_expect();
    a_play(2, 1'b0);
    @(negedge clk);
    set_info_random(14, 8);
    encode(3, 'o7, 'o5);
    a_expect();
    a_play(2, 1'b1);
    repeat (3) @(negedge clk);
    a_compare("fs_coincident", 1'b1);

    // Long noisy all-zero run on the K=7 instance: one flipped bit per 25 symbols
    for (int i = 0; i < B_N; i++) begin
      if (i % 25 == 0) pos = $urandom_range(0, 24);
      s = 2'b00;
      if (i % 25 == pos) s[$urandom_range(0, 1)] = 1'b1;
      b_iv  = 1'b1;
      b_sym = s;
      @(negedge clk);
    end
    b_iv = 1'b0;
    repeat (3) @(negedge clk);
    chk("long_out_count", b_nout, B_N - B_TB + 1);
    chk("long_normalised", b_norm > 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
